layer_blit_scheduler: RTL

- Sequences per-frame composition of the game screen: on each frame start, steps the layer index 0..NUM_LAYERS-1 into the game-state descriptor logic, latches the returned source rectangle (VRAM) and destination origin (framebuffer), and issues one blit per layer to the copy engine over a valid/ready + done handshake.
- After the last layer, requests a framebuffer swap and returns to idle.
- Sits between the game-state process, the VRAM-to-framebuffer copy engine, and the display buffer controller.

---
 rtl/layer_blit_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/layer_blit_scheduler.sv
// Per-frame layer compositor: walks layers 0..NUM_LAYERS-1, issues one blit per layer, then requests a swap.
// Optional blit_done watchdog enabled by defining BLIT_TIMEOUT_EN.
module layer_blit_scheduler #(
    parameter int NUM_LAYERS     = 14,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_start,
    output logic [31:0] o_layer,
    input  logic [9:0]  i_vram_inicio_X,
    input  logic [9:0]  i_vram_inicio_Y,
    input  logic [9:0]  i_vram_final_X,
    input  logic [9:0]  i_vram_final_Y,
    input  logic [9:0]  i_FB_X,
    input  logic [9:0]  i_FB_Y,
    output logic        o_blit_valid,
    input  logic        i_blit_ready,
    output logic [9:0]  o_blit_src_x,
    output logic [9:0]  o_blit_src_y,
    output logic [10:0] o_blit_w,
    output logic [10:0] o_blit_h,
    output logic [9:0]  o_blit_dst_x,
    output logic [9:0]  o_blit_dst_y,
    input  logic        i_blit_done,
    output logic        o_swap_req,
    input  logic        i_swap_ack,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_overrun,
    output logic        o_blit_error
);
    if (NUM_LAYERS < 1 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048576) begin : g_bad_cfg
        $error("layer_blit_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT_DONE, S_NEXT, S_SWAP} state_t;

    localparam logic [31:0] LAST_LAYER  = 32'(NUM_LAYERS - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_settle;
    logic [31:0] r_layer;
    logic        r_blit_valid;
    logic [9:0]  r_src_x, r_src_y, r_dst_x, r_dst_y;
    logic [10:0] r_w, r_h;
    logic        r_swap_req, r_busy, r_frame_done, r_overrun;

    // Inclusive end coordinates; widen to 11 bits so a full 1024-pixel span fits.
    logic        w_degenerate;
    logic [10:0] w_width, w_height;
    assign w_degenerate = (i_vram_final_X < i_vram_inicio_X) || (i_vram_final_Y < i_vram_inicio_Y);
    assign w_width      = {1'b0, i_vram_final_X} - {1'b0, i_vram_inicio_X} + 11'd1;
    assign w_height     = {1'b0, i_vram_final_Y} - {1'b0, i_vram_inicio_Y} + 11'd1;

`ifdef BLIT_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] r_wd_cnt;
    logic        r_blit_error;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_settle     <= '0;
            r_layer      <= '0;
            r_blit_valid <= 1'b0;
            r_src_x      <= '0;
            r_src_y      <= '0;
            r_dst_x      <= '0;
            r_dst_y      <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_swap_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef BLIT_TIMEOUT_EN
            r_wd_cnt     <= '0;
            r_blit_error <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            // The swap_ack cycle is still SWAP, so a coincident frame_start is an overrun too.
            r_overrun    <= i_frame_start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_layer  <= '0;
                        r_settle <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_src_x <= i_vram_inicio_X;
                        r_src_y <= i_vram_inicio_Y;
                        r_dst_x <= i_FB_X;
                        r_dst_y <= i_FB_Y;
                        r_w     <= w_width;
                        r_h     <= w_height;
                        if (w_degenerate) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_blit_valid <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (i_blit_ready) begin
                        r_blit_valid <= 1'b0;
                        r_state      <= S_WAIT_DONE;
`ifdef BLIT_TIMEOUT_EN
                        r_wd_cnt     <= '0;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (i_blit_done) begin
                        r_state <= S_NEXT;
`ifdef BLIT_TIMEOUT_EN
                    end else if (r_wd_cnt == TIMEOUT_LAST) begin
                        r_blit_error <= 1'b1;
                        r_state      <= S_NEXT;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 20'd1;
`endif
                    end
                end
                S_NEXT: begin
                    if (r_layer == LAST_LAYER) begin
                        r_swap_req <= 1'b1;
                        r_state    <= S_SWAP;
                    end else begin
                        r_layer  <= r_layer + 32'd1;
                        r_settle <= '0;
                        r_state  <= S_SELECT;
                    end
                end
                S_SWAP: begin
                    if (i_swap_ack) begin
                        r_swap_req   <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_layer      <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_layer         = r_layer;
    assign o_blit_valid    = r_blit_valid;
    assign o_blit_src_x    = r_src_x;
    assign o_blit_src_y    = r_src_y;
    assign o_blit_w        = r_w;
    assign o_blit_h        = r_h;
    assign o_blit_dst_x    = r_dst_x;
    assign o_blit_dst_y    = r_dst_y;
    assign o_swap_req      = r_swap_req;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_frame_done;
    assign o_frame_overrun = r_overrun;
`ifdef BLIT_TIMEOUT_EN
    assign o_blit_error    = r_blit_error;
`else
    assign o_blit_error    = 1'b0;
`endif
endmodule
